cmd_point: RTL and testbench
============================

// Module: cmd_point
//
// PURPOSE
//  Command (instruction) pointer register for the sequencer.
//  Holds the address of the current command and updates it once per clock on a command opcode.
//  Supported updates: absolute jump, relative skip forward, relative skip backward.
//  Downstream fetch logic reads addr_point and uses ready to tell when the pointer is valid.
//
// PARAMETERS
//  BUS_WIDTH       32  width of addr_to / addr_point in bits (>= 2)
//  CMD_POINT_BASE  0   value loaded into addr_point on reset (truncated to BUS_WIDTH)
//
// PORTS
//  clk         in   1          system clock; all state updates on the rising edge
//  nreset      in   1          synchronous, active-high reset (1 = reset); legacy port name
//  opcode      in   3          one-hot command: 000 NUL, 001 JMP, 010 SJF, 100 SJB
//  addr_to     in   BUS_WIDTH  jump target (JMP) or skip distance (SJF/SJB)
//  addr_point  out  BUS_WIDTH  current command pointer (registered)
//  ready       out  1          1 = pointer valid and opcodes accepted
//
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-high.
//  - Reset: when nreset=1 at a rising edge:
//    - addr_point <= CMD_POINT_BASE
//    - ready <= 0
//    - opcode is ignored.
//    - A reset asserted mid-operation overrides any opcode present on that edge.
//  - Ready: at the first rising edge with nreset=0, ready <= 1.
//    - ready stays 1 until the next reset.
//    - Opcodes are acted on only at edges where ready=1 and nreset=0.
//  - Opcode decode, registered, 1-cycle latency: the new addr_point is visible right after the edge that sampled the opcode.
//    - NUL 000: addr_point holds.
//    - JMP 001: addr_point <= addr_to.
//    - SJF 010: addr_point <= addr_point + addr_to.
//    - SJB 100: addr_point <= addr_point - addr_to.
//    - Any other code (011, 101, 110, 111): treated as NUL, addr_point holds.
//  - Arithmetic: unsigned, modulo 2^BUS_WIDTH. Wrap-around is silent; no carry or borrow output.
//  - Combinational paths: opcode and addr_to are sampled every edge; there is no input-to-output combinational path.
//  - A held opcode is re-executed every cycle. For example, SJF held for 3 cycles adds addr_to three times.
//  - addr_to changing on the same edge as the opcode: the value sampled at that edge is used.
//
// TESTING (clk period 1 us, BUS_WIDTH=32, CMD_POINT_BASE=0)
//  1. Reset: hold nreset=1 for 2 cycles, then release.
//     -> addr_point=0x00000000 and ready=0 during reset.
//     -> ready=1 one edge after release.
//  2. JMP: addr_to=0x00001234, opcode=001 for 1 cycle, then NUL for 10 cycles.
//     -> addr_point=0x00001234 after the edge, and it holds.
//  3. SJF then SJB: addr_to=2, opcode=010 for 1 cycle.
//     -> addr_point=0x00001236.
//     Then opcode=100 for 1 cycle.
//     -> addr_point=0x00001234.
//  4. Wrap-around:
//     - JMP 0xFFFFFFFF, then SJF 2 -> addr_point=0x00000001.
//     - From 0, SJB 1 -> addr_point=0xFFFFFFFF.
//  5. Illegal and held opcodes:
//     - opcode=011 with addr_to=5 -> addr_point unchanged.
//     - SJF 2 held for 3 cycles from 0x10 -> addr_point=0x16.
//  6. Mid-operation reset: nreset=1 on the same edge as JMP 0xABCD.
//     -> addr_point=0x00000000 and ready=0.
//     -> After release, the first opcode is accepted only once ready=1.

Source files
------------

// File: rtl/cmd_point.sv
// Sequencer command pointer: holds the current command address and updates it
// once per clock from a one-hot opcode (absolute jump, skip forward, skip backward).
module cmd_point #(
    parameter int                   BUS_WIDTH      = 32,
    parameter logic [BUS_WIDTH-1:0] CMD_POINT_BASE = '0
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [2:0]           opcode,
    input  logic [BUS_WIDTH-1:0] addr_to,
    output logic [BUS_WIDTH-1:0] addr_point,
    output logic                 ready
);

    localparam logic [2:0] OP_NUL = 3'b000;
    localparam logic [2:0] OP_JMP = 3'b001;
    localparam logic [2:0] OP_SJF = 3'b010;
    localparam logic [2:0] OP_SJB = 3'b100;

    logic [BUS_WIDTH-1:0] r_addr;
    logic                 r_ready;
    logic [BUS_WIDTH-1:0] w_next_addr;

    // Multi-hot and unused codes fall through to hold; add/sub wrap modulo 2^BUS_WIDTH.
    function automatic logic [BUS_WIDTH-1:0] next_addr(
        input logic [2:0]           op,
        input logic [BUS_WIDTH-1:0] cur,
        input logic [BUS_WIDTH-1:0] arg
    );
        logic [BUS_WIDTH-1:0] res;
        res = cur;
        case (op)
            OP_NUL:  res = cur;
            OP_JMP:  res = arg;
            OP_SJF:  res = cur + arg;
            OP_SJB:  res = cur - arg;
            default: res = cur;
        endcase
        return res;
    endfunction

    always_comb begin
        w_next_addr = next_addr(opcode, r_addr, addr_to);
    end

    // Stage boundary: pointer and ready register; reset wins over any opcode on the same edge.
    always_ff @(posedge clk) begin
        if (nreset) begin
            r_addr  <= CMD_POINT_BASE;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            if (r_ready) begin
                r_addr <= w_next_addr;
            end
        end
    end

    assign addr_point = r_addr;
    assign ready      = r_ready;

endmodule

// File: tb/tb_cmd_point.sv
// Self-checking bench for cmd_point: directed scenarios plus randomized traffic
// against a behavioural pointer model.
`timescale 1ns/1ps
module tb_cmd_point;

    localparam int BW = 32;

    logic          clk;
    logic          nreset;
    logic [2:0]    opcode;
    logic [BW-1:0] addr_to;
    logic [BW-1:0] addr_point;
    logic          ready;

    int n_pass;
    int n_total;

    // Behavioural model state
    logic [BW-1:0] m_addr;
    logic          m_ready;

    cmd_point #(
        .BUS_WIDTH      (BW),
        .CMD_POINT_BASE ('0)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .opcode     (opcode),
        .addr_to    (addr_to),
        .addr_point (addr_point),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    // Advance one edge, apply the spec rules to the model, settle 1 ns past the edge.
    task automatic tick();
        @(posedge clk);
        if (nreset) begin
            m_addr  = '0;
            m_ready = 1'b0;
        end else begin
            if (m_ready) begin
                if (opcode == 3'b001)      m_addr = addr_to;
                else if (opcode == 3'b010) m_addr = m_addr + addr_to;
                else if (opcode == 3'b100) m_addr = m_addr - addr_to;
            end
            m_ready = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        nreset  = 1'b1;
        opcode  = 3'b001;
        addr_to = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if (addr_point !== 32'h0) $display("FAIL reset_addr cyc%0d actual=%h expected=%h", i, addr_point, 32'h0);
            else n_pass++;
            n_total++;
            if (ready !== 1'b0) $display("FAIL reset_ready cyc%0d actual=%b expected=0", i, ready);
            else n_pass++;
        end
        // First edge after release only raises ready; the JMP present is not taken.
        nreset  = 1'b0;
        addr_to = 32'h0000_0055;
        tick();
        n_total++;
        if (ready !== 1'b1) $display("FAIL release_ready actual=%b expected=1", ready);
        else n_pass++;
        n_total++;
        if (addr_point !== 32'h0) $display("FAIL release_addr actual=%h expected=%h", addr_point, 32'h0);
        else n_pass++;
        opcode = 3'b000;
    endtask

    task automatic test_jmp();
        addr_to = 32'h0000_1234;
        opcode  = 3'b001;
        tick();
        n_total++;
        if (addr_point !== 32'h0000_1234) $display("FAIL jmp actual=%h expected=%h", addr_point, 32'h0000_1234);
        else n_pass++;
        opcode = 3'b000;
        for (int i = 0; i < 10; i++) begin
            addr_to = $urandom;
            tick();
            n_total++;
            if (addr_point !== 32'h0000_1234) $display("FAIL nul_hold cyc%0d actual=%h expected=%h", i, addr_point, 32'h0000_1234);
            else n_pass++;
        end
    endtask

    task automatic test_skip();
        addr_to = 32'd2;
        opcode  = 3'b010;
        tick();
        n_total++;
        if (addr_point !== 32'h0000_1236) $display("FAIL sjf actual=%h expected=%h", addr_point, 32'h0000_1236);
        else n_pass++;
        opcode = 3'b100;
        tick();
        n_total++;
        if (addr_point !== 32'h0000_1234) $display("FAIL sjb actual=%h expected=%h", addr_point, 32'h0000_1234);
        else n_pass++;
        opcode = 3'b000;
    endtask

    task automatic test_wrap();
        opcode  = 3'b001;
        addr_to = 32'hFFFF_FFFF;
        tick();
        n_total++;
        if (addr_point !== 32'hFFFF_FFFF) $display("FAIL wrap_jmp actual=%h expected=%h", addr_point, 32'hFFFF_FFFF);
        else n_pass++;
        opcode  = 3'b010;
        addr_to = 32'd2;
        tick();
        n_total++;
        if (addr_point !== 32'h0000_0001) $display("FAIL wrap_sjf actual=%h expected=%h", addr_point, 32'h0000_0001);
        else n_pass++;
        opcode  = 3'b001;
        addr_to = 32'd0;
        tick();
        opcode  = 3'b100;
        addr_to = 32'd1;
        tick();
        n_total++;
        if (addr_point !== 32'hFFFF_FFFF) $display("FAIL wrap_sjb actual=%h expected=%h", addr_point, 32'hFFFF_FFFF);
        else n_pass++;
        opcode = 3'b000;
    endtask

    task automatic test_illegal_held();
        logic [2:0] bad [4];
        logic [BW-1:0] exp_held;
        bad = '{3'b011, 3'b101, 3'b110, 3'b111};
        opcode  = 3'b001;
        addr_to = 32'h10;
        tick();
        for (int i = 0; i < 4; i++) begin
            opcode  = bad[i];
            addr_to = 32'd5;
            tick();
            n_total++;
            if (addr_point !== 32'h10) $display("FAIL illegal_%b actual=%h expected=%h", bad[i], addr_point, 32'h10);
            else n_pass++;
        end
        opcode  = 3'b010;
        addr_to = 32'd2;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_held = 32'h10 + 32'(2 * i);
            n_total++;
            if (addr_point !== exp_held) $display("FAIL held_sjf step%0d actual=%h expected=%h", i, addr_point, exp_held);
            else n_pass++;
        end
        opcode = 3'b000;
    endtask

    task automatic test_mid_reset();
        opcode  = 3'b001;
        addr_to = 32'h0000_ABCD;
        nreset  = 1'b1;
        tick();
        n_total++;
        if (addr_point !== 32'h0) $display("FAIL midrst_addr actual=%h expected=%h", addr_point, 32'h0);
        else n_pass++;
        n_total++;
        if (ready !== 1'b0) $display("FAIL midrst_ready actual=%b expected=0", ready);
        else n_pass++;
        nreset = 1'b0;
        tick();
        n_total++;
        if (addr_point !== 32'h0 || ready !== 1'b1) $display("FAIL midrst_release actual=%h/%b expected=%h/1", addr_point, ready, 32'h0);
        else n_pass++;
        tick();
        n_total++;
        if (addr_point !== 32'h0000_ABCD) $display("FAIL midrst_first_op actual=%h expected=%h", addr_point, 32'h0000_ABCD);
        else n_pass++;
        opcode = 3'b000;
    endtask

    task automatic test_random();
        logic [2:0] legal [4];
        legal = '{3'b000, 3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 400; i++) begin
            nreset = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 4) == 0) opcode = 3'($urandom_range(0, 7));
            else opcode = legal[$urandom_range(0, 3)];
            addr_to = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            tick();
            n_total++;
            if (addr_point !== m_addr || ready !== m_ready)
                $display("FAIL random cyc%0d actual=%h/%b expected=%h/%b", i, addr_point, ready, m_addr, m_ready);
            else n_pass++;
        end
        nreset = 1'b0;
        opcode = 3'b000;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_addr  = '0;
        m_ready = 1'b0;
        nreset  = 1'b1;
        opcode  = 3'b000;
        addr_to = '0;
        test_reset();
        test_jmp();
        test_skip();
        test_wrap();
        test_illegal_held();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
